// File: rtl/ysyx_25020037_lsu_axi_if.sv
// AXI4-Lite channel bundle between the LSU (master) and memory (slave).
interface ysyx_25020037_lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [2:0]          arsize;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [2:0]          awsize;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, arsize, rready,
    output awaddr, awvalid, awsize, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arsize, rready,
    input  awaddr, awvalid, awsize, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25020037_lsu_axi.sv
// Load/store unit between EXU and WBU: aligns byte lanes, extends sub-word loads,
// flags misaligned accesses and bus errors, and passes non-memory results through.
module ysyx_25020037_lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [DATA_W-1:0]       in_wdata,
  input  logic                    in_ren,
  input  logic                    in_wen,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [1:0]              out_fault,
  ysyx_25020037_lsu_axi_if.master axi
);
  localparam int OFFS_W = $clog2(DATA_W / 8);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] FAULT_OK = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUS = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_r;
  logic [OFFS_W-1:0] offs_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic              misal_r;
  logic [OFFS_W-1:0] in_offs_s;
  logic              in_misal_s;

  // Doublewords only exist on a 64-bit path; on 32 bits they are reported as misaligned.
  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] s);
    logic [2:0] mask;
    mask = (3'd1 << s) - 3'd1;
    return (|(a & mask)) || ((DATA_W == 32) && (s == 2'd3));
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] s, input logic [OFFS_W-1:0] o);
    logic [STRB_W-1:0] base;
    int nbytes;
    nbytes = 32'sd1 << s;
    for (int i = 0; i < STRB_W; i++) begin
      base[i] = (i < nbytes);
    end
    return base << o;
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] d,
                                                     input logic [OFFS_W-1:0] o,
                                                     input logic [1:0] s,
                                                     input logic uns);
    logic [DATA_W-1:0] sh;
    logic sign;
    int nbits;
    sh = d >> {o, 3'b000};
    nbits = ((32'sd8 << s) > DATA_W) ? DATA_W : (32'sd8 << s);
    sign = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      sign = (i == nbits - 1) ? sh[i] : sign;
    end
    sign = sign & ~uns;
    for (int i = 0; i < DATA_W; i++) begin
      sh[i] = (i >= nbits) ? sign : sh[i];
    end
    return sh;
  endfunction

  assign in_offs_s  = in_addr[OFFS_W-1:0];
  assign in_misal_s = misaligned(in_addr[2:0], in_size);

  // Request/response FSM; every output to EXU, WBU and the bus is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_fault   <= FAULT_OK;
      offs_r      <= '0;
      size_r      <= 2'd0;
      unsigned_r  <= 1'b0;
      misal_r     <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.arsize  <= 3'd0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.awsize  <= 3'd0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready   <= 1'b0;
            offs_r     <= in_offs_s;
            size_r     <= in_size;
            unsigned_r <= in_unsigned;
            misal_r    <= in_misal_s;
            if (in_ren) begin
              state_r     <= RADDR;
              axi.araddr  <= in_addr;
              axi.arsize  <= {1'b0, in_size};
              axi.arvalid <= ~in_misal_s;
            end else if (in_wen) begin
              state_r     <= WREQ;
              axi.awaddr  <= in_addr;
              axi.awsize  <= {1'b0, in_size};
              axi.wdata   <= in_wdata << {in_offs_s, 3'b000};
              axi.wstrb   <= in_misal_s ? '0 : lane_strb(in_size, in_offs_s);
              axi.awvalid <= ~in_misal_s;
              axi.wvalid  <= ~in_misal_s;
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              out_data  <= DATA_W'(in_addr);
              out_fault <= FAULT_OK;
            end
          end
        end
        RADDR: begin
          if (misal_r) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            out_data  <= '0;
            out_fault <= FAULT_MISALIGN;
          end else if (axi.arvalid && axi.arready) begin
            state_r     <= RDATA;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (axi.rvalid && axi.rready) begin
            state_r    <= DONE;
            axi.rready <= 1'b0;
            out_valid  <= 1'b1;
            out_data   <= (axi.rresp != 2'd0) ? '0 : load_extract(axi.rdata, offs_r, size_r, unsigned_r);
            out_fault  <= (axi.rresp != 2'd0) ? FAULT_BUS : FAULT_OK;
          end
        end
        WREQ: begin
          if (misal_r) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            out_data  <= '0;
            out_fault <= FAULT_MISALIGN;
          end else begin
            // Each channel retires on its own handshake; leave once neither is pending.
            if (axi.awready) axi.awvalid <= 1'b0;
            if (axi.wready)  axi.wvalid  <= 1'b0;
            if ((axi.awready || !axi.awvalid) && (axi.wready || !axi.wvalid)) begin
              state_r    <= WRESP;
              axi.bready <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (axi.bvalid && axi.bready) begin
            state_r    <= DONE;
            axi.bready <= 1'b0;
            out_valid  <= 1'b1;
            out_data   <= '0;
            out_fault  <= (axi.bresp != 2'd0) ? FAULT_BUS : FAULT_OK;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready    <= 1'b1;
          out_valid   <= 1'b0;
          axi.arvalid <= 1'b0;
          axi.rready  <= 1'b0;
          axi.awvalid <= 1'b0;
          axi.wvalid  <= 1'b0;
          axi.bready  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/ysyx_25020037_lsu_axi.md
Name: ysyx_25020037_lsu_axi

Overview:
Parametrised load/store unit between EXU and WBU that drives an AXI4-Lite master port.
- Adds byte-lane alignment, sub-word loads with sign/zero extension, and misalignment detection.
- Issues AW and W concurrently and reports bus-error responses as faults.
- Non-memory instructions pass straight through in one handshake.
- Supports 32- or 64-bit data paths.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus/data width; legal 32 or 64; SZ=3 (doubleword) legal only when 64
OFFS_W, derived log2(DATA_W/8), lane-offset bits of address

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  request valid from EXU
in_ready  out  1  LSU accepts request
in_addr  in  ADDR_W  effective address, or pass-through result for non-mem ops
in_wdata  in  DATA_W  store data, right-aligned
in_ren  in  1  load
in_wen  in  1  store; in_ren takes priority if both set
in_size  in  2  0=B 1=H 2=W 3=D
in_unsigned  in  1  zero-extend the load
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts
out_data  out  DATA_W  load data, or pass-through in_addr zero-extended
out_fault  out  2  0=ok 1=misaligned 2=bus error
araddr  out  ADDR_W; arvalid  out  1; arready  in  1; arsize  out  3
rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rready  out  1
awaddr  out  ADDR_W; awvalid  out  1; awready  in  1; awsize  out  3
wdata  out  DATA_W; wstrb  out  DATA_W/8; wvalid  out  1; wready  in  1
bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State = IDLE; in_ready=1.
  - out_valid, arvalid, rready, awvalid, wvalid, bready = 0.
  - out_data, out_fault, araddr, awaddr, arsize, awsize, wdata, wstrb = 0.
  - Reset mid-transaction abandons the transaction and deasserts all valids immediately.
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- in_ready is 1 only in IDLE. Accept on in_valid&in_ready and register all request fields.
- Misalignment: addr mod 2^size != 0 on a load/store → DONE with fault=1 and no bus activity.
- Non-memory op → DONE next cycle with out_data = in_addr and fault=0.
- Load, from IDLE → RADDR:
  - arvalid=1, araddr=addr, arsize=size.
  - arvalid&arready → RDATA with rready=1.
  - rvalid&rready → capture result, rready=0, go to DONE.
  - Result extraction:
    - shift rdata right by 8*addr[OFFS_W-1:0];
    - take the low 8<<size bits;
    - sign-extend unless in_unsigned.
  - rresp!=0 → fault=2, out_data=0.
- Store, from IDLE → WREQ:
  - awvalid=1 and wvalid=1 in the same cycle.
  - wdata = in_wdata << 8*offset.
  - wstrb = ((1<<(1<<size))-1) << offset.
  - awvalid and wvalid each drop independently on their own handshake, including when both handshakes occur in the same cycle.
  - Both done → WRESP with bready=1.
  - bvalid&bready → bready=0, go to DONE; fault=2 if bresp!=0.
- DONE: out_valid=1; out_data and out_fault are held stable until out_ready.
  - out_valid&out_ready → IDLE, out_valid=0, in_ready=1 next cycle.
  - Minimum latency for a non-memory op: accept → out_valid = 1 cycle. Next request can be accepted the cycle after the out handshake.
- AXI rules:
  - Valids never drop before their ready.
  - Address and data are stable while valid is asserted.
  - rvalid/bvalid outside the expecting state are ignored.
  - Slave readies may be tied high; a zero-wait handshake must complete in one cycle per channel.
- Fault loads and fault stores never write memory.

Test Plan:
- Byte store: DATA_W=32, store size=0 at addr 0x80000003, wdata 0xAB → awaddr=0x80000003, wdata=0xAB000000, wstrb=4'b1000; bresp=0 → out_valid, fault=0.
- Signed half load: load size=1 at 0x80000002, rdata=0x8001_1234 → out_data=0xFFFF8001. Same with in_unsigned=1 → 0x00008001.
- Misaligned word: load size=2 at 0x80000002 → no arvalid ever; out_valid with fault=1 two cycles after accept.
- Staggered store handshakes: awready delayed 3 cycles, wready immediate → wvalid drops after cycle 1, awvalid holds until cycle 3, then bready; bresp=2'b10 → fault=2.
- Backpressure and pass-through: out_ready low 5 cycles on a pass-through of 0x1234 → out_valid and out_data stay 0x1234 and in_ready stays 0; out_ready=1 → IDLE next cycle.
- Mid-transaction reset: assert rst while in RDATA → all valids/readies 0 asynchronously; the first request after reset completes normally. DATA_W=64 doubleword load at 0x...08 → out_data = full rdata.
